// File: rtl/alarme_expediente_param.sv
// End-of-shift siren controller: hour/weekday clock, daily piece counter,
// debounced all-machines-stopped detector and a siren FSM with timeout and silence.
module alarme_expediente_param #(
    parameter int NMAQ          = 4,
    parameter int NPROD         = 8,
    parameter int META          = 10,
    parameter int HORA_FIM      = 18,
    parameter int SEXTA         = 5,
    parameter int PARADA_CICLOS = 4,
    parameter int DURACAO       = 16,
    parameter int HORA_INI      = 8,
    parameter int DIA_INI       = 1
) (
    input  logic             i_clk_2,
    input  logic             i_rst_n,
    input  logic             i_tick_hora,
    input  logic             i_peca,
    input  logic [NMAQ-1:0]  i_maq_ativa,
    input  logic             i_ack,
    output logic             o_sirene,
    output logic [4:0]       o_hora,
    output logic [2:0]       o_dia,
    output logic [NPROD-1:0] o_producao_cnt,
    output logic [1:0]       o_estado
);

    localparam int SW = $clog2(PARADA_CICLOS + 1);
    localparam int TW = $clog2(DURACAO + 1);
    localparam logic [SW-1:0] PARADA_V = SW'(PARADA_CICLOS);
    localparam logic [TW-1:0] TIMER_MAX = TW'(DURACAO - 1);

    typedef enum logic [1:0] {
        OCIOSO     = 2'b00,
        TOCANDO    = 2'b01,
        SILENCIADO = 2'b10
    } t_estado;

    logic [4:0]       r_hora;
    logic [2:0]       r_dia;
    logic [NPROD-1:0] r_prod;
    logic [SW-1:0]    r_stop;
    logic             r_paradas;
    t_estado          r_estado;
    logic [TW-1:0]    r_timer;
    logic             r_sirene;

    logic             w_rollover;
    logic [NPROD-1:0] w_prod_next;
    logic [SW-1:0]    w_stop_next;
    logic             w_noite;
    logic             w_sexta;
    logic             w_meta_ok;
    logic             w_cond;
    t_estado          w_estado_next;
    logic [TW-1:0]    w_timer_next;
    logic             w_sirene_next;

    assign w_rollover = i_tick_hora && (r_hora == 5'd23);

    // A piece arriving on the rollover edge belongs to the new day.
    always_comb begin
        w_prod_next = r_prod;
        if (w_rollover)
            w_prod_next = i_peca ? NPROD'(1) : '0;
        else if (i_peca && (r_prod != '1))
            w_prod_next = r_prod + NPROD'(1);
    end

    always_comb begin
        w_stop_next = r_stop;
        if (|i_maq_ativa)
            w_stop_next = '0;
        else if (r_stop != PARADA_V)
            w_stop_next = r_stop + SW'(1);
    end

    always_ff @(posedge i_clk_2) begin
        if (!i_rst_n) begin
            r_hora    <= 5'(HORA_INI);
            r_dia     <= 3'(DIA_INI);
            r_prod    <= '0;
            r_stop    <= '0;
            r_paradas <= 1'b0;
        end else begin
            if (i_tick_hora) begin
                r_hora <= w_rollover ? 5'd0 : r_hora + 5'd1;
                if (w_rollover)
                    r_dia <= (r_dia == 3'd6) ? 3'd0 : r_dia + 3'd1;
            end
            r_prod    <= w_prod_next;
            r_stop    <= w_stop_next;
            r_paradas <= (w_stop_next == PARADA_V);
        end
    end

    // Widened so a META beyond the counter range simply never matches.
    assign w_noite   = {27'd0, r_hora} >= 32'($unsigned(HORA_FIM));
    assign w_sexta   = ({29'd0, r_dia} == 32'($unsigned(SEXTA)));
    assign w_meta_ok = {{(32-NPROD){1'b0}}, r_prod} >= 32'($unsigned(META));
    assign w_cond    = r_paradas && (w_noite || (w_sexta && w_meta_ok));

    always_ff @(posedge i_clk_2) begin
        if (!i_rst_n) begin
            r_estado <= OCIOSO;
            r_timer  <= '0;
            r_sirene <= 1'b0;
        end else begin
            r_estado <= w_estado_next;
            r_timer  <= w_timer_next;
            r_sirene <= w_sirene_next;
        end
    end

    always_comb begin
        w_estado_next = r_estado;
        case (r_estado)
            OCIOSO:     if (w_cond) w_estado_next = TOCANDO;
            TOCANDO: begin
                if (!w_cond)                  w_estado_next = OCIOSO;
                else if (i_ack)               w_estado_next = SILENCIADO;
                else if (r_timer == TIMER_MAX) w_estado_next = SILENCIADO;
            end
            SILENCIADO: if (!w_cond) w_estado_next = OCIOSO;
            default:    w_estado_next = OCIOSO;
        endcase
    end

    always_comb begin
        w_timer_next  = r_timer;
        w_sirene_next = (w_estado_next == TOCANDO);
        case (r_estado)
            OCIOSO:  if (w_cond) w_timer_next = '0;
            TOCANDO: w_timer_next = r_timer + TW'(1);
            default: w_timer_next = r_timer;
        endcase
    end

    assign o_sirene       = r_sirene;
    assign o_hora         = r_hora;
    assign o_dia          = r_dia;
    assign o_producao_cnt = r_prod;
    assign o_estado       = r_estado;

endmodule

// File: tb/tb_alarme_expediente_param.sv
// Directed bench for alarme_expediente_param with default parameters.
module tb_alarme_expediente_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_hora;
    logic       peca;
    logic [3:0] maq;
    logic       ack;
    logic       sirene;
    logic [4:0] hora;
    logic [2:0] dia;
    logic [7:0] prod;
    logic [1:0] estado;

    int n_checks = 0;
    int n_fail   = 0;

    alarme_expediente_param dut (
        .i_clk_2        (clk),
        .i_rst_n        (rst_n),
        .i_tick_hora    (tick_hora),
        .i_peca         (peca),
        .i_maq_ativa    (maq),
        .i_ack          (ack),
        .o_sirene       (sirene),
        .o_hora         (hora),
        .o_dia          (dia),
        .o_producao_cnt (prod),
        .o_estado       (estado)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick_hora = 1'b1;
        repeat (n) step();
        tick_hora = 1'b0;
    endtask

    task automatic pecas(input int n);
        peca = 1'b1;
        repeat (n) step();
        peca = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick_hora = 1'b0; peca = 1'b0; ack = 1'b0; maq = 4'b1111;
        step();
        rst_n = 1'b1;
    endtask

    // Night alarm: 10 hour ticks to 18:00, machines stop, siren up after 5 edges.
    task automatic arm_night();
        do_reset();
        ticks(10);
        maq = 4'b0000;
        repeat (5) step();
    endtask

    // From reset (day 1, 08h) advance to day 5, 10h and count n pieces.
    task automatic go_friday(input int n);
        do_reset();
        ticks(98);
        pecas(n);
    endtask

    task automatic test_reset();
        do_reset();
        step();
        n_checks++; if (hora !== 5'd8) begin n_fail++; $display("FAIL reset_hora got %0d exp 8", hora); end
        n_checks++; if (dia !== 3'd1) begin n_fail++; $display("FAIL reset_dia got %0d exp 1", dia); end
        n_checks++; if (prod !== 8'd0) begin n_fail++; $display("FAIL reset_prod got %0d exp 0", prod); end
        n_checks++; if (estado !== 2'b00) begin n_fail++; $display("FAIL reset_estado got %b exp 00", estado); end
        n_checks++; if (sirene !== 1'b0) begin n_fail++; $display("FAIL reset_sirene got %b exp 0", sirene); end
        $display("test_reset: hora=%0d dia=%0d prod=%0d estado=%b sirene=%b", hora, dia, prod, estado, sirene);
    endtask

    task automatic test_noite();
        logic       exp_s;
        logic [1:0] exp_e;
        do_reset();
        ticks(10);
        n_checks++; if (hora !== 5'd18) begin n_fail++; $display("FAIL noite_hora got %0d exp 18", hora); end
        maq = 4'b0000;
        for (int k = 1; k <= 23; k++) begin
            step();
            exp_s = (k >= 5 && k <= 20);
            exp_e = (k < 5) ? 2'b00 : (k <= 20) ? 2'b01 : 2'b10;
            n_checks++; if (sirene !== exp_s) begin n_fail++; $display("FAIL noite_sirene edge=%0d got %b exp %b", k, sirene, exp_s); end
            n_checks++; if (estado !== exp_e) begin n_fail++; $display("FAIL noite_estado edge=%0d got %b exp %b", k, estado, exp_e); end
        end
        maq = 4'b0001;
        step();
        n_checks++; if (estado !== 2'b10) begin n_fail++; $display("FAIL noite_rearm1 got %b exp 10", estado); end
        step();
        n_checks++; if (estado !== 2'b00) begin n_fail++; $display("FAIL noite_rearm2 got %b exp 00", estado); end
        $display("test_noite: done, estado=%b", estado);
    endtask

    task automatic test_sexta();
        go_friday(10);
        n_checks++; if (dia !== 3'd5 || hora !== 5'd10) begin n_fail++; $display("FAIL sexta_tempo got dia=%0d hora=%0d exp 5/10", dia, hora); end
        n_checks++; if (prod !== 8'd10) begin n_fail++; $display("FAIL sexta_prod got %0d exp 10", prod); end
        maq = 4'b0000;
        repeat (4) step();
        n_checks++; if (sirene !== 1'b0) begin n_fail++; $display("FAIL sexta_pre got %b exp 0", sirene); end
        step();
        n_checks++; if (sirene !== 1'b1) begin n_fail++; $display("FAIL sexta_sirene got %b exp 1", sirene); end
        $display("test_sexta meta=10: sirene=%b estado=%b", sirene, estado);
        go_friday(9);
        n_checks++; if (prod !== 8'd9) begin n_fail++; $display("FAIL sexta9_prod got %0d exp 9", prod); end
        maq = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_checks++; if (sirene !== 1'b0 || estado !== 2'b00) begin n_fail++; $display("FAIL sexta9_quiet edge=%0d got sirene=%b estado=%b exp 0/00", k, sirene, estado); end
        end
        $display("test_sexta meta=9: sirene=%b estado=%b", sirene, estado);
    endtask

    task automatic test_ack();
        arm_night();
        n_checks++; if (sirene !== 1'b1) begin n_fail++; $display("FAIL ack_armed got %b exp 1", sirene); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++; if (sirene !== 1'b0) begin n_fail++; $display("FAIL ack_sirene got %b exp 0", sirene); end
        n_checks++; if (estado !== 2'b10) begin n_fail++; $display("FAIL ack_estado got %b exp 10", estado); end
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        repeat (3) step();
        n_checks++; if (sirene !== 1'b0 || estado !== 2'b10) begin n_fail++; $display("FAIL ack_second got sirene=%b estado=%b exp 0/10", sirene, estado); end
        $display("test_ack: sirene=%b estado=%b", sirene, estado);
    endtask

    task automatic test_cond_vs_ack();
        arm_night();
        maq = 4'b0100;
        step();
        n_checks++; if (estado !== 2'b01 || sirene !== 1'b1) begin n_fail++; $display("FAIL cond_edge1 got estado=%b sirene=%b exp 01/1", estado, sirene); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++; if (estado !== 2'b00) begin n_fail++; $display("FAIL cond_beats_ack got %b exp 00", estado); end
        n_checks++; if (sirene !== 1'b0) begin n_fail++; $display("FAIL cond_sirene got %b exp 0", sirene); end
        $display("test_cond_vs_ack: estado=%b sirene=%b", estado, sirene);
    endtask

    task automatic test_rollover();
        do_reset();
        ticks(135);
        pecas(7);
        n_checks++; if (hora !== 5'd23 || dia !== 3'd6 || prod !== 8'd7) begin n_fail++; $display("FAIL roll_pre got hora=%0d dia=%0d prod=%0d exp 23/6/7", hora, dia, prod); end
        tick_hora = 1'b1; peca = 1'b1;
        step();
        tick_hora = 1'b0; peca = 1'b0;
        n_checks++; if (hora !== 5'd0) begin n_fail++; $display("FAIL roll_hora got %0d exp 0", hora); end
        n_checks++; if (dia !== 3'd0) begin n_fail++; $display("FAIL roll_dia got %0d exp 0", dia); end
        n_checks++; if (prod !== 8'd1) begin n_fail++; $display("FAIL roll_prod got %0d exp 1", prod); end
        $display("test_rollover: hora=%0d dia=%0d prod=%0d", hora, dia, prod);
    endtask

    task automatic test_saturacao();
        pecas(253);
        n_checks++; if (prod !== 8'd254) begin n_fail++; $display("FAIL sat_254 got %0d exp 254", prod); end
        pecas(1);
        n_checks++; if (prod !== 8'd255) begin n_fail++; $display("FAIL sat_255 got %0d exp 255", prod); end
        pecas(5);
        n_checks++; if (prod !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d exp 255", prod); end
        $display("test_saturacao: prod=%0d", prod);
    endtask

    task automatic test_reset_mid_alarm();
        arm_night();
        pecas(3);
        n_checks++; if (sirene !== 1'b1) begin n_fail++; $display("FAIL midrst_armed got %b exp 1", sirene); end
        rst_n = 1'b0;
        ack = 1'b1;
        step();
        rst_n = 1'b1;
        ack = 1'b0;
        n_checks++; if (hora !== 5'd8 || dia !== 3'd1 || prod !== 8'd0) begin n_fail++; $display("FAIL midrst_cnt got hora=%0d dia=%0d prod=%0d exp 8/1/0", hora, dia, prod); end
        n_checks++; if (estado !== 2'b00 || sirene !== 1'b0) begin n_fail++; $display("FAIL midrst_fsm got estado=%b sirene=%b exp 00/0", estado, sirene); end
        $display("test_reset_mid_alarm: estado=%b sirene=%b", estado, sirene);
    endtask

    initial begin
        rst_n = 1'b0; tick_hora = 1'b0; peca = 1'b0; ack = 1'b0; maq = 4'b1111;
        test_reset();
        test_noite();
        test_sexta();
        test_ack();
        test_cond_vs_ack();
        test_rollover();
        test_saturacao();
        test_reset_mid_alarm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarme_expediente_param.md
Name: alarme_expediente_param

Overview:
- Parametrised, clocked successor to the end-of-shift siren logic for the factory.
- Keeps its own hour and weekday counters, a per-day piece counter, and a debounced "all machines stopped" detector.
- A siren state machine adds a timeout and an operator acknowledge/silence, neither of which a purely combinational alarm provides.
- Sits between the switch/button inputs and the LED/siren outputs of the board top level.

Parameters:
- NMAQ, 4, number of machines monitored (width of maq_ativa).
- NPROD, 8, width of the production counter.
- META, 10, pieces per day that count as "production met".
- HORA_FIM, 18, first hour considered "after hours" (0..23).
- SEXTA, 5, weekday index of Friday (0 = Sunday .. 6 = Saturday).
- PARADA_CICLOS, 4, consecutive cycles with all machines idle before "paradas" asserts (>= 1).
- DURACAO, 16, maximum cycles the siren sounds before self-silencing (>= 1).
- HORA_INI, 8, hour loaded at reset.
- DIA_INI, 1, weekday loaded at reset.

Ports:
- clk_2  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- tick_hora  in  1  one-cycle pulse that advances the hour.
- peca  in  1  one-cycle pulse: one piece produced.
- maq_ativa  in  NMAQ  bit i = 1 means machine i is running.
- ack  in  1  operator silence request (level, sampled each cycle).
- sirene  out  1  siren drive, registered.
- hora  out  5  current hour, 0..23.
- dia  out  3  current weekday, 0..6.
- producao_cnt  out  NPROD  pieces counted today.
- estado  out  2  FSM state: 00 OCIOSO, 01 TOCANDO, 10 SILENCIADO.

Behaviour:
- Reset (rst_n = 0 at an edge):
  - hora = HORA_INI, dia = DIA_INI, producao_cnt = 0.
  - Stop counter = 0, paradas = 0.
  - estado = OCIOSO, sirene = 0, siren timer = 0.
  - Reset overrides every other input in that cycle, including mid-alarm.
- Hour/day counters:
  - On tick_hora: hora increments.
  - hora = 23 with tick_hora: hora -> 0 and dia increments; dia = 6 wraps to 0.
  - Day rollover is the edge where hora goes 23 -> 0.
- Production counter:
  - peca increments producao_cnt, saturating at 2^NPROD - 1.
  - Rollover clears the count.
  - peca in the same cycle as a rollover: count becomes 1, i.e. the piece is credited to the new day.
- Stop detector:
  - While maq_ativa == 0, the counter increments each cycle, saturating at PARADA_CICLOS.
  - paradas = 1 when the counter equals PARADA_CICLOS; both are registered.
  - Any bit of maq_ativa = 1 clears the counter and paradas on the next edge.
- Alarm condition (combinational from registered state):
  - noite = (hora >= HORA_FIM)
  - sexta = (dia == SEXTA)
  - meta_ok = (producao_cnt >= META)
  - cond = paradas & (noite | (sexta & meta_ok))
- FSM, with sirene registered as (next estado == TOCANDO):
  - OCIOSO: cond = 1 -> TOCANDO, timer loaded with 0.
  - TOCANDO: timer increments each cycle. Transition priority:
    1. cond = 0 -> OCIOSO
    2. ack = 1 -> SILENCIADO
    3. timer == DURACAO-1 -> SILENCIADO
  - SILENCIADO: siren off. cond = 0 -> OCIOSO (re-arm); otherwise stay, and ack is ignored.
- Latency:
  - sirene rises on the edge after the first cycle cond = 1.
  - Without ack, sirene stays high for exactly DURACAO cycles.
  - sirene falls on the edge where ack is sampled, or where cond is seen low.
- Width rules:
  - META and HORA_FIM comparisons are unsigned.
  - META > 2^NPROD - 1 means meta_ok never asserts (legal configuration, no error).

Test Plan:
1. Reset with defaults, then hold tick_hora at 0 -> hora = 8, dia = 1, producao_cnt = 0, estado = 00, sirene = 0.
2. Ten tick_hora pulses (hora = 18), then maq_ativa = 0000 held:
   - paradas = 1 after 4 edges.
   - sirene = 1 from edge 5 for exactly 16 cycles.
   - estado then = 10 and sirene = 0.
   - Setting maq_ativa = 0001 returns estado = 00.
3. Friday path:
   - Drive to dia = 5, hora = 10, then 10 peca pulses (producao_cnt = 10).
   - maq_ativa = 0 -> siren sounds.
   - Repeat with 9 pulses -> no siren.
4. Alarm sounding, ack = 1 for one cycle -> sirene = 0 next edge and estado = 10. A second ack has no effect.
5. Alarm sounding, maq_ativa = 0100 -> estado = 00 two edges later: paradas clears, then the FSM exits. cond = 0 beats a simultaneous ack.
6. Rollovers and reset:
   - hora = 23, dia = 6, producao_cnt = 7, with tick_hora and peca in the same cycle -> hora = 0, dia = 0, producao_cnt = 1.
   - Counter saturates at 255 with NPROD = 8.
   - rst_n = 0 mid-alarm -> all outputs at reset values next edge.
